cu_flag_status: RTL
===================

CU_FLAG_STATUS -- requirements
Module: cu_flag_status

Interface
REQ-001 Parameter ALU_LAT, default 1, cycles from ps_alu_en high to alu_ps_* flags being valid (legal range 1..4).
REQ-002 Parameter MUL_LAT, default 1, cycles from ps_mul_en high to mul_ps_* flags being valid (legal range 1..4).
REQ-003 Parameter SHF_LAT, default 1, cycles from ps_shf_en high to shf_ps_* flags being valid (legal range 1..4).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- ps_alu_en, ps_mul_en, ps_shf_en  in  1 each  unit issue strobes from PS.
- alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av  in  1 each  ALU flags.
- mul_ps_mn, mul_ps_mv  in  1 each  multiplier flags.
- shf_ps_sz, shf_ps_sv  in  1 each  shifter flags.
- ps_astat_wen  in  1  PS write strobe for ASTAT.
- ps_stky_wen  in  1  PS write strobe for STKY.
- ps_stat_wdt  in  8  PS write data; bits [2:0] only are used for STKY.
- ps_cond_code  in  4  condition select.
- stat_ps_astat  out  8  ASTAT: [0]AZ [1]AN [2]AC [3]AV [4]MN [5]MV [6]SZ [7]SV.
- stat_ps_stky  out  3  STKY: [0]AVS [1]MVS [2]SVS.
- stat_ps_cond  out  1  condition result.

Function
REQ-005 Each unit SHALL have its own delay line of depth <unit>_LAT carrying its enable, so that the update strobe upd_<unit> is high exactly <unit>_LAT cycles after the enable was sampled high.
REQ-006 On each edge where upd_alu is high, ASTAT[3:0] SHALL load {av,ac,an,az}, and all other bits are unchanged.
REQ-007 On each edge where upd_mul is high, ASTAT[5:4] SHALL load {mv,mn}.
REQ-008 On each edge where upd_shf is high, ASTAT[7:6] SHALL load {sv,sz}.
REQ-009 Fields whose unit has no update strobe SHALL hold their value, and flag inputs SHALL be ignored outside their update cycle.
REQ-010 Sticky bits SHALL be set, never cleared, by hardware:
- AVS |= av on upd_alu.
- MVS |= mv on upd_mul.
- SVS |= sv on upd_shf.
REQ-011 When ps_astat_wen is high, ASTAT SHALL load ps_stat_wdt, except that any field with an update strobe active on the same edge takes the unit value (unit wins per field).
REQ-012 When ps_stky_wen is high, STKY SHALL load ps_stat_wdt[2:0] OR'd with any same-edge hardware set; a write of 0 therefore clears only bits not being set that cycle.
REQ-013 Back-to-back enables on consecutive cycles SHALL produce back-to-back updates with no loss, since each delay line is a pure shift register with no stall.
REQ-014 Updates from different units on the same edge SHALL all apply, because their fields are disjoint.
REQ-015 stat_ps_cond SHALL be combinational from the registered ASTAT, so it reflects updates made on the previous edge with no bypass, decoded by ps_cond_code as follows:
- 0 EQ=AZ; 1 NE=~AZ; 2 LT=AN; 3 GE=~AN.
- 4 LE=AN|AZ; 5 GT=~(AN|AZ).
- 6 AC; 7 ~AC; 8 AV; 9 ~AV; 10 MV; 11 ~MV; 12 MN; 13 ~MN; 14 SV.
- 15 TRUE=1.
REQ-016 stat_ps_astat and stat_ps_stky SHALL be direct register outputs.

Reset
REQ-017 While reset is low, ASTAT and STKY SHALL be 0 and all delay-line stages SHALL be 0, so that stat_ps_cond equals 0 for codes 0, 2, 4, 6, 8, 10, 12 and 14, and 1 for all other codes.
REQ-018 Reset asserted mid-flight SHALL discard pending updates: no update occurs for enables sampled before reset deasserted.
REQ-019 Enables sampled on the first edge after reset deassertion SHALL be honoured normally.

Verification
REQ-020 Scenario 1: with ALU_LAT=1, pulse ps_alu_en at cycle 0, then drive az=1, an=0, ac=1, av=1 at cycle 1 -> ASTAT=0x0D and STKY=0x1 after edge 1, and cond code 6 gives 1.
REQ-021 Scenario 2: with MUL_LAT=3, pulse ps_mul_en at cycles 0 and 1 with mv=1 only at cycle 3 and mv=0 at cycle 4 -> ASTAT[5]=1 after edge 3 and 0 after edge 4, and MVS stays 1.
REQ-022 Scenario 3: on the same edge, ps_astat_wen=1 with wdt=0xFF and upd_alu with all ALU flags 0 -> ASTAT=0xF0.
REQ-023 Scenario 4: with STKY=0x7, apply ps_stky_wen=1 with wdt=0x0 while upd_shf has sv=1 -> STKY=0x4.
REQ-024 Scenario 5: pulse ps_alu_en, then assert reset for one cycle before the update cycle -> ASTAT stays 0x00 and no update occurs after release.
REQ-025 Scenario 6: set ASTAT=0x03 via PS write, then sweep ps_cond_code 0..15 -> outputs 1,0,1,0,1,0,0,1,0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/cu_flag_status_if.sv
// cu_flag_status_if
//   Bundles the PS/execution-unit side of the flag and status block.
//   master : PS and execution units (drive strobes, flags, write data,
//            condition select; observe status outputs)
//   slave  : cu_flag_status (consumes the above, drives status outputs)
//
//   ps_alu_en/ps_mul_en/ps_shf_en  unit issue strobes
//   alu_ps_az/an/ac/av             ALU flags
//   mul_ps_mn/mv                   multiplier flags
//   shf_ps_sz/sv                   shifter flags
//   ps_astat_wen/ps_stky_wen       PS write strobes for ASTAT / STKY
//   ps_stat_wdt[7:0]               PS write data (STKY uses [2:0])
//   ps_cond_code[3:0]              condition select
//   stat_ps_astat[7:0]             ASTAT register
//   stat_ps_stky[2:0]              STKY register
//   stat_ps_cond                   decoded condition
interface cu_flag_status_if;
    logic       ps_alu_en;
    logic       ps_mul_en;
    logic       ps_shf_en;
    logic       alu_ps_az;
    logic       alu_ps_an;
    logic       alu_ps_ac;
    logic       alu_ps_av;
    logic       mul_ps_mn;
    logic       mul_ps_mv;
    logic       shf_ps_sz;
    logic       shf_ps_sv;
    logic       ps_astat_wen;
    logic       ps_stky_wen;
    logic [7:0] ps_stat_wdt;
    logic [3:0] ps_cond_code;
    logic [7:0] stat_ps_astat;
    logic [2:0] stat_ps_stky;
    logic       stat_ps_cond;

    modport master (
        output ps_alu_en, ps_mul_en, ps_shf_en,
        output alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av,
        output mul_ps_mn, mul_ps_mv,
        output shf_ps_sz, shf_ps_sv,
        output ps_astat_wen, ps_stky_wen, ps_stat_wdt, ps_cond_code,
        input  stat_ps_astat, stat_ps_stky, stat_ps_cond
    );

    modport slave (
        input  ps_alu_en, ps_mul_en, ps_shf_en,
        input  alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av,
        input  mul_ps_mn, mul_ps_mv,
        input  shf_ps_sz, shf_ps_sv,
        input  ps_astat_wen, ps_stky_wen, ps_stat_wdt, ps_cond_code,
        output stat_ps_astat, stat_ps_stky, stat_ps_cond
    );
endinterface

// File: rtl/cu_flag_status.sv
// cu_flag_status
//   Arithmetic status (ASTAT) and sticky status (STKY) registers fed by
//   the ALU, multiplier and shifter, plus the condition-code decoder.
//
//   Parameters ALU_LAT/MUL_LAT/SHF_LAT (1..4): cycles from a unit's issue
//   strobe being sampled to its flags being valid and captured.
//
//   Ports
//     clk    sole clock, rising edge
//     reset  asynchronous, active-low
//     bus    cu_flag_status_if.slave (strobes, flags, PS writes, status)
//
//   ASTAT: [0]AZ [1]AN [2]AC [3]AV [4]MN [5]MV [6]SZ [7]SV
//   STKY : [0]AVS [1]MVS [2]SVS
module cu_flag_status #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned SHF_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    cu_flag_status_if.slave  bus
);

    // Per-unit issue pipelines: bit 0 holds the enable sampled on the last
    // edge, the top bit marks the cycle in which that unit's flags land.
    logic [ALU_LAT-1:0] alu_dly;
    logic [MUL_LAT-1:0] mul_dly;
    logic [SHF_LAT-1:0] shf_dly;

    logic upd_alu;
    logic upd_mul;
    logic upd_shf;

    logic [7:0] astat_q;
    logic [7:0] astat_nxt;
    logic [2:0] stky_q;
    logic [2:0] stky_nxt;
    logic [2:0] stky_set;
    logic       cond;

    // Size cast keeps the low LAT bits of {dly, en}, which is a one-place
    // shift that also degenerates cleanly to a single flop when LAT == 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_dly <= '0;
            mul_dly <= '0;
            shf_dly <= '0;
        end else begin
            alu_dly <= ALU_LAT'({alu_dly, bus.ps_alu_en});
            mul_dly <= MUL_LAT'({mul_dly, bus.ps_mul_en});
            shf_dly <= SHF_LAT'({shf_dly, bus.ps_shf_en});
        end
    end

    assign upd_alu = alu_dly[ALU_LAT-1];
    assign upd_mul = mul_dly[MUL_LAT-1];
    assign upd_shf = shf_dly[SHF_LAT-1];

    // PS write provides the base value, then each unit landing this edge
    // overrides its own field, so the unit wins field by field.
    always_comb begin
        astat_nxt = bus.ps_astat_wen ? bus.ps_stat_wdt : astat_q;
        if (upd_alu) begin
            astat_nxt[3:0] = {bus.alu_ps_av, bus.alu_ps_ac,
                              bus.alu_ps_an, bus.alu_ps_az};
        end
        if (upd_mul) begin
            astat_nxt[5:4] = {bus.mul_ps_mv, bus.mul_ps_mn};
        end
        if (upd_shf) begin
            astat_nxt[7:6] = {bus.shf_ps_sv, bus.shf_ps_sz};
        end
    end

    // Hardware sets are OR'd in after any PS write so a same-edge overflow
    // can never be lost to a software clear.
    always_comb begin
        stky_set = {upd_shf & bus.shf_ps_sv,
                    upd_mul & bus.mul_ps_mv,
                    upd_alu & bus.alu_ps_av};
        stky_nxt = (bus.ps_stky_wen ? bus.ps_stat_wdt[2:0] : stky_q) | stky_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            astat_q <= '0;
            stky_q  <= '0;
        end else begin
            astat_q <= astat_nxt;
            stky_q  <= stky_nxt;
        end
    end

    // Decoded from the registered ASTAT only; no bypass of this edge's update.
    always_comb begin
        cond = 1'b0;
        unique case (bus.ps_cond_code)
            4'd0:  cond =  astat_q[0];
            4'd1:  cond = ~astat_q[0];
            4'd2:  cond =  astat_q[1];
            4'd3:  cond = ~astat_q[1];
            4'd4:  cond =  (astat_q[1] | astat_q[0]);
            4'd5:  cond = ~(astat_q[1] | astat_q[0]);
            4'd6:  cond =  astat_q[2];
            4'd7:  cond = ~astat_q[2];
            4'd8:  cond =  astat_q[3];
            4'd9:  cond = ~astat_q[3];
            4'd10: cond =  astat_q[5];
            4'd11: cond = ~astat_q[5];
            4'd12: cond =  astat_q[4];
            4'd13: cond = ~astat_q[4];
            4'd14: cond =  astat_q[7];
            4'd15: cond =  1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign bus.stat_ps_astat = astat_q;
    assign bus.stat_ps_stky  = stky_q;
    assign bus.stat_ps_cond  = cond;

endmodule
